// File: rtl/timer_pkg.sv
// Shared types and helpers for the run/pause/done display timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // All segments off (active-low); reserved for display blanking.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} hex font.
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b0100111;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000100;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Board-side signal bundle of the timer: buttons/switches in, display out.
interface timer_ctrl_if;
  logic       btn_start;
  logic       btn_pause;
  logic       btn_load;
  logic       clear;
  logic       dir;
  logic [3:0] preset;
  logic [3:0] q;
  logic [6:0] seg;
  logic       tick;
  logic       busy;
  logic       done;

  // Board / bench side: drives the buttons and switches, observes the display.
  modport master (
    output btn_start, btn_pause, btn_load, clear, dir, preset,
    input  q, seg, tick, busy, done
  );

  // Timer side.
  modport slave (
    input  btn_start, btn_pause, btn_load, clear, dir, preset,
    output q, seg, tick, busy, done
  );
endinterface

// File: rtl/timer_ctrl_btn_sync_edge.sv
// Two-flop synchronizer with optional registered rising-edge pulse.
module btn_sync_edge #(
  parameter int EDGE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic sync1_q;
  logic sync2_q;

  // Bring the asynchronous input into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  if (EDGE != 0) begin : g_edge
    logic prev_q;
    logic pulse_q;

    // Registered one-cycle pulse on each synchronized rising edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prev_q  <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        prev_q  <= sync2_q;
        pulse_q <= sync2_q & ~prev_q;
      end
    end

    assign q_o = pulse_q;
  end else begin : g_level
    assign q_o = sync2_q;
  end

endmodule

// File: rtl/timer_ctrl.sv
// Run/pause/done sequencer for the 4-bit up/down seven-segment timer.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic         clk,
  input  logic         rst,
  timer_ctrl_if.slave  bus
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic start_evt;
  logic pause_evt;
  logic load_evt;
  logic clear_s;

  btn_sync_edge #(.EDGE(1)) u_start (.clk(clk), .rst(rst), .d_i(bus.btn_start), .q_o(start_evt));
  btn_sync_edge #(.EDGE(1)) u_pause (.clk(clk), .rst(rst), .d_i(bus.btn_pause), .q_o(pause_evt));
  btn_sync_edge #(.EDGE(1)) u_load  (.clk(clk), .rst(rst), .d_i(bus.btn_load),  .q_o(load_evt));
  btn_sync_edge #(.EDGE(0)) u_clear (.clk(clk), .rst(rst), .d_i(bus.clear),     .q_o(clear_s));

  state_e           state_q;
  logic [3:0]       q_q;
  logic [DIV_W-1:0] div_q;

  logic       tick_d;
  logic [3:0] q_step_d;
  logic       term_d;

  // Tick is the last divider count while running; the step and terminal
  // test use dir as it stands in the tick cycle.
  always_comb begin
    tick_d   = (state_q == RUN) && (div_q == DIV_LAST);
    q_step_d = bus.dir ? (q_q + 4'd1) : (q_q - 4'd1);
    term_d   = bus.dir ? (q_step_d == 4'hF) : (q_step_d == 4'h0);
  end

  // Sequencer: clear overrides everything, then tick > pause > start > load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= 4'd0;
      div_q   <= '0;
    end else if (clear_s) begin
      state_q <= IDLE;
      q_q     <= 4'd0;
      div_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_evt) begin
            state_q <= RUN;
            div_q   <= '0;
          end else if (load_evt) begin
            q_q <= bus.preset;
          end
        end
        RUN: begin
          if (tick_d) begin
            q_q   <= q_step_d;
            div_q <= '0;
            // Reaching the terminal value wins over a same-cycle pause.
            if (term_d)         state_q <= DONE;
            else if (pause_evt) state_q <= PAUSE;
          end else begin
            div_q <= div_q + DIV_W'(1);
            if (pause_evt) state_q <= PAUSE;
          end
        end
        PAUSE: begin
          // Divider keeps its frozen value so the interrupted period resumes.
          if (start_evt) state_q <= RUN;
        end
        DONE: begin
          if (start_evt) begin
            state_q <= RUN;
            div_q   <= '0;
          end else if (load_evt) begin
            q_q     <= bus.preset;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.q    = q_q;
  assign bus.seg  = hex7seg(q_q);
  assign bus.tick = tick_d;
  assign bus.busy = (state_q == RUN) || (state_q == PAUSE);
  assign bus.done = (state_q == DONE);

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl with TICK_DIV = 4.
module tb_timer_ctrl;
  import timer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  timer_ctrl_if bus ();

  timer_ctrl #(.TICK_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected {q, busy, done} right after each tick's update edge.
  logic [5:0] exp_q[$];
  bit spacing_en = 1'b0;
  int last_tick  = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every tick pops one expectation and checks the post-update state.
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.tick === 1'b1) begin
        if (spacing_en && last_tick >= 0) check("tick_spacing", cyc - last_tick, 4);
        last_tick = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick: tick seen at q=%0d, none expected", bus.q);
        end else begin
          e = exp_q.pop_front();
          @(negedge clk);
          check("tick_q", bus.q, e[5:2]);
          check("tick_busy_done", {bus.busy, bus.done}, e[1:0]);
        end
      end
    end
  end

  task automatic press(input int which);
    case (which)
      0: bus.btn_start = 1'b1;
      1: bus.btn_pause = 1'b1;
      default: bus.btn_load = 1'b1;
    endcase
    repeat (3) @(negedge clk);
    bus.btn_start = 1'b0;
    bus.btn_pause = 1'b0;
    bus.btn_load  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_tick(input string name);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: no tick within 60 cycles", name);
  endtask

  task automatic wait_done(input string name);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: done not reached within 200 cycles", name);
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    repeat (4) @(negedge clk);
    check("clear_q", bus.q, 0);
    check("clear_busy", bus.busy, 0);
    bus.clear = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int cnt;
    int nt;
    bus.btn_start = 1'b0;
    bus.btn_pause = 1'b0;
    bus.btn_load  = 1'b0;
    bus.clear     = 1'b0;
    bus.dir       = 1'b1;
    bus.preset    = 4'd0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_q", bus.q, 0);
    check("rst_seg", bus.seg, 7'b1000000);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_tick", bus.tick, 0);

    // Load 3 and count up to 15
    bus.preset = 4'd3;
    press(2);
    check("load3_q", bus.q, 3);
    check("load3_seg", bus.seg, 7'b0110000);
    bus.dir = 1'b1;
    for (int v = 4; v <= 14; v++) exp_q.push_back({4'(v), 2'b10});
    exp_q.push_back({4'd15, 2'b01});
    last_tick  = -1;
    spacing_en = 1'b1;
    press(0);
    wait_done("up_done");
    spacing_en = 1'b0;
    repeat (8) @(negedge clk);
    check("up_hold_q", bus.q, 15);
    check("up_seg", bus.seg, 7'b0001110);
    check("up_done", bus.done, 1);
    check("up_busy", bus.busy, 0);
    check("up_all_ticks", exp_q.size(), 0);

    // Load 2 from DONE, count down to 0, restart wraps to 15
    bus.preset = 4'd2;
    press(2);
    check("load2_q", bus.q, 2);
    check("load2_idle", {bus.busy, bus.done}, 0);
    bus.dir = 1'b0;
    exp_q.push_back({4'd1, 2'b10});
    exp_q.push_back({4'd0, 2'b01});
    press(0);
    wait_done("down_done");
    repeat (2) @(negedge clk);
    check("down_q", bus.q, 0);
    exp_q.push_back({4'd15, 2'b10});
    bus.btn_start = 1'b1;
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (cnt == 3) bus.btn_start = 1'b0;
      if (bus.tick === 1'b1) break;
    end
    bus.btn_start = 1'b0;
    check("restart_tick_lat", cnt, 7);
    @(negedge clk);
    pulse_clear();

    // Pause after two divider cycles, hold, resume
    bus.preset = 4'd5;
    bus.dir    = 1'b1;
    press(2);
    check("load5_q", bus.q, 5);
    bus.btn_start = 1'b1;
    repeat (2) @(negedge clk);
    bus.btn_pause = 1'b1;
    @(negedge clk);
    bus.btn_start = 1'b0;
    @(negedge clk);
    bus.btn_pause = 1'b0;
    repeat (4) @(negedge clk);
    nt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) nt++;
    end
    check("pause_no_tick", nt, 0);
    check("pause_q", bus.q, 5);
    check("pause_busy", bus.busy, 1);
    exp_q.push_back({4'd6, 2'b10});
    bus.btn_start = 1'b1;
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (cnt == 3) bus.btn_start = 1'b0;
      if (bus.tick === 1'b1) break;
    end
    bus.btn_start = 1'b0;
    check("resume_tick_lat", cnt, 5);

    // Pause coinciding with the 6->7 tick
    @(negedge clk);
    bus.btn_pause = 1'b1;
    exp_q.push_back({4'd7, 2'b10});
    repeat (2) @(negedge clk);
    bus.btn_pause = 1'b0;
    nt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.tick === 1'b1) nt++;
    end
    check("coinc_ticks", nt, 1);
    check("coinc_q", bus.q, 7);
    check("coinc_paused", {bus.busy, bus.done}, 2'b10);
    pulse_clear();

    // Pause coinciding with the 14->15 tick: DONE wins
    bus.preset = 4'd13;
    press(2);
    exp_q.push_back({4'd14, 2'b10});
    exp_q.push_back({4'd15, 2'b01});
    bus.btn_start = 1'b1;
    repeat (3) @(negedge clk);
    bus.btn_start = 1'b0;
    wait_tick("tick_to_14");
    @(negedge clk);
    bus.btn_pause = 1'b1;
    repeat (2) @(negedge clk);
    bus.btn_pause = 1'b0;
    repeat (10) @(negedge clk);
    check("term_pause_q", bus.q, 15);
    check("term_pause_done", bus.done, 1);
    check("term_pause_busy", bus.busy, 0);

    // Clear during PAUSE at q=9 with a simultaneous start press
    bus.preset = 4'd8;
    press(2);
    check("load8_q", bus.q, 8);
    exp_q.push_back({4'd9, 2'b10});
    bus.btn_start = 1'b1;
    repeat (3) @(negedge clk);
    bus.btn_start = 1'b0;
    wait_tick("tick_to_9");
    bus.btn_pause = 1'b1;
    repeat (2) @(negedge clk);
    bus.btn_pause = 1'b0;
    repeat (6) @(negedge clk);
    check("clr_pre_q", bus.q, 9);
    check("clr_pre_busy", bus.busy, 1);
    bus.clear     = 1'b1;
    bus.btn_start = 1'b1;
    repeat (2) @(negedge clk);
    check("clr_lat_busy", bus.busy, 1);
    @(negedge clk);
    check("clr_q", bus.q, 0);
    check("clr_seg", bus.seg, 7'b1000000);
    check("clr_busy", bus.busy, 0);
    bus.btn_start = 1'b0;
    repeat (6) @(negedge clk);
    check("clr_hold_busy", bus.busy, 0);
    bus.clear = 1'b0;
    repeat (6) @(negedge clk);
    check("clr_start_ignored", bus.busy, 0);
    check("clr_after_q", bus.q, 0);

    // Asynchronous reset mid-run at q=5
    bus.preset = 4'd5;
    press(2);
    press(0);
    check("prerst_busy", bus.busy, 1);
    check("prerst_q", bus.q, 5);
    #2 rst = 1'b1;
    #1;
    check("arst_q", bus.q, 0);
    check("arst_seg", bus.seg, 7'b1000000);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
